// File: rtl/rv_sim_pkg.sv
// Shared simulator definitions: byte/instruction sizing, loader states and
// the MSB-first byte selector used by the instruction loader.
package rv_sim_pkg;

  localparam int unsigned BYTE_SIZE   = 8;
  localparam logic [31:0] NOP         = 32'b0;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } loader_state_e;

  // Byte idx of a word in fetch order: idx 0 is bits 31:24.
  function automatic logic [BYTE_SIZE-1:0] instr_byte(input logic [31:0] word,
                                                      input logic [1:0]  idx);
    case (idx)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      2'd3:    return word[7:0];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/instruction_loader.sv
// Streams 32-bit instruction words into byte-wide instruction memory,
// MSB first at ascending addresses, with overflow detection and completion.
module instruction_loader
  import rv_sim_pkg::*;
#(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned INSTR_SIZE = 32,
  parameter int unsigned MAX_LINES  = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  valid_i,
  input  logic [INSTR_SIZE-1:0] data_i,
  input  logic                  last_i,
  output logic                  ready_o,
  output logic                  mem_we_o,
  output logic [PC_SIZE-1:0]    mem_addr_o,
  output logic [BYTE_SIZE-1:0]  mem_wdata_o,
  output logic [PC_SIZE-1:0]    count_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Highest base address at which a whole word still fits.
  localparam logic [PC_SIZE-1:0] LAST_BASE = PC_SIZE'(MAX_LINES - INSTR_BYTES);
  localparam logic [PC_SIZE-1:0] ONE       = PC_SIZE'(1);

  loader_state_e         state_q, state_d;
  logic [PC_SIZE-1:0]    addr_q, addr_d;
  logic [PC_SIZE-1:0]    count_q, count_d;
  logic [1:0]            idx_q, idx_d;
  logic [INSTR_SIZE-1:0] word_q, word_d;
  logic                  last_q, last_d;
  logic                  room_s;

  assign room_s  = (addr_q <= LAST_BASE);
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      idx_q   <= 2'd0;
      word_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    word_d      = word_q;
    last_d      = last_q;
    ready_o     = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    done_o      = 1'b0;
    err_o       = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        done_o = (state_q == DONE);
        err_o  = (state_q == ERROR);
        if (start_i) begin
          state_d = ACCEPT;
          addr_d  = '0;
          count_d = '0;
          idx_d   = 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      ACCEPT: begin
        ready_o = room_s;
        if (valid_i && room_s) begin
          word_d  = data_i;
          last_d  = last_i;
          idx_d   = 2'd0;
          state_d = WRITE;
        end else if (valid_i) begin
          // Word left unconsumed; the source sees ready_o low.
          state_d = ERROR;
        end else begin
          state_d = ACCEPT;
        end
      end
      WRITE: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = instr_byte(word_q, idx_q);
        addr_d      = addr_q + ONE;
        count_d     = count_q + ONE;
        idx_d       = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = last_q ? DONE : ACCEPT;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench: a 4096-byte loader and an 8-byte loader share one stimulus
// stream; bench-side byte memories record every write strobe.
module tb_instruction_loader;
  import rv_sim_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni, start, valid, last;
  logic [31:0] data;

  logic        ready_a, we_a, done_a, err_a;
  logic [31:0] addr_a, count_a;
  logic [7:0]  wdata_a;
  logic        ready_b, we_b, done_b, err_b;
  logic [31:0] addr_b, count_b;
  logic [7:0]  wdata_b;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] mem_a [0:15];
  logic [7:0] mem_b [0:15];
  int         wr_a = 0;
  logic       hi_b = 1'b0;
  int         base;
  int         w;
  logic       hs;

  logic [7:0]  exp1  [0:7] = '{8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h01, 8'h13};
  logic [7:0]  exp_de[0:3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [31:0] words [0:2] = '{32'h01020304, 32'h05060708, 32'h090A0B0C};

  always #5 clk = ~clk;

  instruction_loader #(.PC_SIZE(32), .INSTR_SIZE(32), .MAX_LINES(4096)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .valid_i(valid), .data_i(data),
    .last_i(last), .ready_o(ready_a), .mem_we_o(we_a), .mem_addr_o(addr_a),
    .mem_wdata_o(wdata_a), .count_o(count_a), .done_o(done_a), .err_o(err_a)
  );

  instruction_loader #(.PC_SIZE(32), .INSTR_SIZE(32), .MAX_LINES(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .valid_i(valid), .data_i(data),
    .last_i(last), .ready_o(ready_b), .mem_we_o(we_b), .mem_addr_o(addr_b),
    .mem_wdata_o(wdata_b), .count_o(count_b), .done_o(done_b), .err_o(err_b)
  );

  always @(posedge clk) begin
    if (we_a) begin
      if (addr_a < 32'd16) mem_a[addr_a[3:0]] <= wdata_a;
      wr_a <= wr_a + 1;
    end
    if (we_b) begin
      if (addr_b < 32'd16) mem_b[addr_b[3:0]] <= wdata_b;
      if (addr_b >= 32'd8) hi_b <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0; start = 1'b0; valid = 1'b0; data = 32'h0; last = 1'b0;
    step(); step();
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_we", 32'(we_a), 32'd0);
    chk("rst_addr", addr_a, 32'd0);
    chk("rst_wdata", 32'(wdata_a), 32'd0);
    chk("rst_count", count_a, 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    rst_ni = 1'b1;
    step();
    chk("idle_ready", 32'(ready_a), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ready", 32'(ready_a), 32'd1);
    chk("start_count", count_a, 32'd0);

    // Two-word program, second word last.
    data = 32'h00500093; last = 1'b0; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("w1_we", 32'(we_a), 32'd1);
      chk("w1_addr", addr_a, 32'(i));
      chk("w1_byte", 32'(wdata_a), 32'(exp1[i]));
      chk("w1_ready_low", 32'(ready_a), 32'd0);
      step();
    end
    chk("w1_ready_again", 32'(ready_a), 32'd1);
    data = 32'h00100113; last = 1'b1; valid = 1'b1;
    step();
    valid = 1'b0; last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("w2_addr", addr_a, 32'(i + 4));
      chk("w2_byte", 32'(wdata_a), 32'(exp1[i + 4]));
      step();
    end
    chk("prog_done", 32'(done_a), 32'd1);
    chk("prog_count", count_a, 32'd8);
    chk("prog_ready", 32'(ready_a), 32'd0);
    for (int i = 0; i < 8; i++) chk("prog_mem", 32'(mem_a[i]), 32'(exp1[i]));
    chk("fill8_done", 32'(done_b), 32'd1);
    chk("fill8_err", 32'(err_b), 32'd0);
    chk("fill8_count", count_b, 32'd8);

    // Restart from DONE, start and valid together: only the start is taken.
    start = 1'b1; valid = 1'b1; data = 32'hDEADBEEF; last = 1'b1;
    step();
    start = 1'b0;
    chk("rs_done_clr", 32'(done_a), 32'd0);
    chk("rs_we", 32'(we_a), 32'd0);
    chk("rs_count", count_a, 32'd0);
    chk("rs_ready", 32'(ready_a), 32'd1);
    step();
    valid = 1'b0; last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rs_addr", addr_a, 32'(i));
      chk("rs_byte", 32'(wdata_a), 32'(exp_de[i]));
      step();
    end
    chk("rs_done_set", 32'(done_a), 32'd1);
    chk("rs_count4", count_a, 32'd4);
    for (int i = 0; i < 4; i++) chk("rs_mem", 32'(mem_a[i]), 32'(exp_de[i]));

    // Backpressure: valid held high over three non-last words.
    start = 1'b1;
    step();
    start = 1'b0;
    base = wr_a;
    w = 0; valid = 1'b1; data = words[0]; last = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("bp_ready", 32'(ready_a), 32'((k % 5) == 0));
      chk("bp_we_and_ready", 32'(we_a & ready_a), 32'd0);
      hs = ready_a & valid;
      step();
      if (hs) begin
        w++;
        if (w < 3) data = words[w];
        else valid = 1'b0;
      end
    end
    chk("bp_ready_end", 32'(ready_a), 32'd1);
    chk("bp_count", count_a, 32'd12);
    chk("bp_writes", 32'(wr_a - base), 32'd12);
    for (int i = 0; i < 12; i++) chk("bp_mem", 32'(mem_a[i]), 32'(i + 1));
    chk("ovf_err", 32'(err_b), 32'd1);
    chk("ovf_ready", 32'(ready_b), 32'd0);
    chk("ovf_count", count_b, 32'd8);
    chk("ovf_no_wr8", 32'(hi_b), 32'd0);
    chk("ovf_mem", 32'(mem_b[7]), 32'h08);

    // Reset after the second byte of a word.
    data = 32'hAABBCCDD; valid = 1'b1;
    base = wr_a;
    step();
    valid = 1'b0;
    chk("rm_addr0", addr_a, 32'd12);
    chk("rm_byte0", 32'(wdata_a), 32'hAA);
    step();
    chk("rm_byte1", 32'(wdata_a), 32'hBB);
    rst_ni = 1'b0;
    step();
    chk("rm_we", 32'(we_a), 32'd0);
    chk("rm_count", count_a, 32'd0);
    chk("rm_state", 32'(dut.state_q), 32'(IDLE));
    rst_ni = 1'b1;
    step(); step();
    chk("rm_writes", 32'(wr_a - base), 32'd2);
    chk("rm_mem12", 32'(mem_a[12]), 32'hAA);
    chk("rm_mem13", 32'(mem_a[13]), 32'hBB);

    // Start with valid from IDLE, then a single-word program.
    start = 1'b1; valid = 1'b1; data = 32'hCAFEF00D; last = 1'b1;
    step();
    start = 1'b0;
    chk("sv_we", 32'(we_a), 32'd0);
    chk("sv_state", 32'(dut.state_q), 32'(ACCEPT));
    step();
    valid = 1'b0; last = 1'b0;
    chk("sv_byte0", 32'(wdata_a), 32'hCA);
    step(); step(); step(); step();
    chk("sv_done", 32'(done_a), 32'd1);
    chk("sv_mem3", 32'(mem_a[3]), 32'h0D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writes a program into byte-wide instruction memory before the simulator runs, so instructions can be loaded from a stream instead of a file. It accepts 32-bit instruction words over a valid/ready handshake and serializes each word into four sequential byte writes, most-significant byte first, at ascending addresses. That byte order matches the fetch path, which reads an instruction as bytes pc+0..pc+3 concatenated MSB-first. It sits between a host/testbench program source and the instruction memory write port, and reports the loaded length and completion.

## Interface
- PC_SIZE, 32, width of byte addresses and length count
- INSTR_SIZE, 32, instruction word width; fixed at 32 (4 bytes)
- MAX_LINES, 4096, instruction memory depth in bytes; multiple of 4, ≥4
- clk_i  input  1  clock; all logic on rising edge
- rst_ni  input  1  synchronous, active-low reset
- start_i  input  1  begin a new load at address 0
- valid_i  input  1  data_i/last_i hold a word
- data_i  input  INSTR_SIZE  instruction word
- last_i  input  1  this word is the final one of the program
- ready_o  output  1  loader accepts a word this cycle
- mem_we_o  output  1  byte write strobe
- mem_addr_o  output  PC_SIZE  byte address
- mem_wdata_o  output  8  byte data
- count_o  output  PC_SIZE  bytes written in the current load
- done_o  output  1  load completed normally
- err_o  output  1  overflow: a word was offered with no room left

## Operation
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- Reset (rst_ni=0 at an edge):
  - State goes to IDLE; address, count and byte index go to 0.
  - All outputs reset to 0.
  - Memory contents are not cleared; a partially written word stays partial.
- Start:
  - IDLE/DONE/ERROR + start_i → ACCEPT.
  - Address and count go to 0; done_o and err_o clear.
  - start_i is ignored in ACCEPT and WRITE.
- ACCEPT:
  - ready_o = (addr ≤ MAX_LINES−4).
  - valid_i & ready_o: capture data_i and last_i, go to WRITE with byte index 0.
  - valid_i & !ready_o: go to ERROR; the word is not consumed.
- WRITE:
  - mem_we_o=1, mem_addr_o=addr, mem_wdata_o = byte[3−idx] of the captured word (idx 0 → bits 31:24).
  - addr and count increment by 1 each cycle.
  - After idx 3: go to DONE if the captured last_i=1, else to ACCEPT.
- DONE: done_o=1, ready_o=0; hold until start_i or reset.
- ERROR: err_o=1, ready_o=0; hold until start_i or reset.
- Widths: addr and count are PC_SIZE bits. count_o always equals the number of bytes written since start; no wrap is possible, because the overflow check precedes any write.

## Timing
- Handshake at edge t → byte writes in cycles t+1..t+4, at addresses base..base+3.
- ready_o is next high at t+5 (non-last word); done_o is high from t+5 (last word).
- Throughput: one word per 5 cycles. ready_o is low throughout WRITE.
- ready_o is combinational from state and addr only; it never depends on valid_i.
- Exact fill: a word at base MAX_LINES−4 is accepted. Afterwards addr = MAX_LINES and ready_o = 0.
- Reset asserted during WRITE aborts the load at that edge; no further writes occur.
- start_i together with valid_i in IDLE: only the start is taken; the word can be accepted from the next cycle.

## Structure
- Shared package rv_sim_pkg holds:
  - BYTE_SIZE = 8
  - NOP = 32'b0
  - INSTR_BYTES = 4
  - typedef enum loader_state_e {IDLE, ACCEPT, WRITE, DONE, ERROR}
- Single module with no sub-modules. The byte serializer is a 2-bit index plus a captured-word register inside instruction_loader.

## Test plan
- Reset, then start. Send 0x00500093 (last=0), then 0x00100113 (last=1). Required:
  - Writes 00,50,00,93,00,10,01,13 at addresses 0..7.
  - done_o=1, count_o=8.
- Backpressure: hold valid_i=1 continuously. Required:
  - ready_o high exactly 1 cycle in 5.
  - No word dropped or duplicated across 3 words.
  - mem_we_o never high while ready_o is high.
- Overflow with MAX_LINES=8: send 3 words, none marked last. Required:
  - Words 1–2 are written; count_o=8.
  - The third offer gives err_o=1, ready_o=0, and no write to address 8.
- Exact fill with MAX_LINES=8: send 2 words, the second with last=1. Required: done_o=1, err_o=0, count_o=8.
- Reset mid-load: drop rst_ni after the second byte of a word. Required:
  - The next cycle shows mem_we_o=0, count_o=0, state IDLE.
  - Bytes 0–1 remain in memory.
- Restart from DONE: assert start_i and load 0xDEADBEEF. Required:
  - done_o clears, then re-asserts.
  - Bytes DE,AD,BE,EF at addresses 0..3; count_o=4.
